// File: rtl/bldc_commutator_if.sv
// Bundles the motor-control command inputs and the per-phase driver outputs of
// one BLDC commutator.
//   master : drives enable/duty_cycle_in/direction/brake/hall, observes outputs
//   slave  : the commutator itself
interface bldc_commutator_if #(
  parameter int unsigned DUTY_CYCLE_WIDTH = 9
);
  logic                        enable;
  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle_in;
  logic                        direction;
  logic                        brake;
  logic [2:0]                  hall;
  logic [DUTY_CYCLE_WIDTH-1:0] duty_a;
  logic [DUTY_CYCLE_WIDTH-1:0] duty_b;
  logic [DUTY_CYCLE_WIDTH-1:0] duty_c;
  logic                        high_z_a;
  logic                        high_z_b;
  logic                        high_z_c;
  logic                        fault_invalid_hall;
  logic                        fault_stall;
  logic [15:0]                 comm_count;

  modport master (
    output enable, duty_cycle_in, direction, brake, hall,
    input  duty_a, duty_b, duty_c, high_z_a, high_z_b, high_z_c,
           fault_invalid_hall, fault_stall, comm_count
  );

  modport slave (
    input  enable, duty_cycle_in, direction, brake, hall,
    output duty_a, duty_b, duty_c, high_z_a, high_z_b, high_z_c,
           fault_invalid_hall, fault_stall, comm_count
  );
endinterface

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation controller.
// Ports:
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : bldc_commutator_if.slave
//              in : enable, duty_cycle_in, direction (1=fwd), brake, hall {C,B,A}
//              out: duty_a/b/c, high_z_a/b/c, fault_invalid_hall, fault_stall,
//                   comm_count (signed, wraps)
module bldc_commutator #(
  parameter int unsigned DUTY_CYCLE_WIDTH   = 9,
  parameter int unsigned HALL_FILTER_CYCLES = 4,
  parameter int unsigned COMM_BLANK_CYCLES  = 8,
  parameter int unsigned STALL_CYCLES       = 5000000
) (
  input logic              clock,
  input logic              reset_n,
  bldc_commutator_if.slave bus
);

  localparam int unsigned FW = $clog2(HALL_FILTER_CYCLES + 1);
  localparam int unsigned BW = $clog2(COMM_BLANK_CYCLES + 1);
  localparam int unsigned SW = $clog2(STALL_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_BLANK, S_BRAKE, S_FAULT} state_t;

  logic [2:0]    hall_s1_q, hall_s2_q;
  logic [2:0]    hall_flt_q, hall_flt_d;
  logic [2:0]    hall_cand_q, hall_cand_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d, flt_cnt_nxt;
  logic          hall_acc;
  logic          hall_valid_d;

  state_t        state_q, state_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          dir_q;
  logic          dir_tgl;
  logic          duty_nz;
  logic          fault_inv_q, fault_inv_d;
  logic          fault_stall_q, fault_stall_d;
  logic [15:0]   count_q, count_d;

  logic [2:0]    fwd_pwm, fwd_low, pwm_mask, low_mask;
  logic [DUTY_CYCLE_WIDTH-1:0] duty_a_q, duty_a_d, duty_b_q, duty_b_d, duty_c_q, duty_c_d;
  logic [2:0]    hz_q, hz_d;

  // Hall filter: a candidate value must be seen on consecutive cycles;
  // any different value restarts the run with itself as the new candidate.
  always_comb begin
    hall_cand_d = hall_cand_q;
    flt_cnt_d   = flt_cnt_q;
    flt_cnt_nxt = flt_cnt_q;
    hall_flt_d  = hall_flt_q;
    hall_acc    = 1'b0;
    if (hall_s2_q == hall_flt_q) begin
      flt_cnt_d = '0;
    end else begin
      if (hall_s2_q == hall_cand_q && flt_cnt_q != '0) begin
        flt_cnt_nxt = flt_cnt_q + 1'b1;
      end else begin
        hall_cand_d = hall_s2_q;
        flt_cnt_nxt = FW'(1);
      end
      if (flt_cnt_nxt == FW'(HALL_FILTER_CYCLES)) begin
        hall_acc   = 1'b1;
        hall_flt_d = hall_s2_q;
        flt_cnt_d  = '0;
      end else begin
        flt_cnt_d = flt_cnt_nxt;
      end
    end
  end

  assign hall_valid_d = (hall_flt_d != 3'b000) && (hall_flt_d != 3'b111);
  assign dir_tgl      = bus.direction != dir_q;
  assign duty_nz      = bus.duty_cycle_in != '0;

  // The filtered hall resets to 000, so IDLE waits for a valid value instead
  // of faulting; invalid-hall faults apply once the motor is being driven.
  // Brake is honoured at the end of a blank interval, not inside it.
  always_comb begin
    state_d       = state_q;
    blank_d       = blank_q;
    stall_d       = '0;
    fault_inv_d   = fault_inv_q;
    fault_stall_d = fault_stall_q;
    count_d       = count_q;
    if (!bus.enable) begin
      state_d       = S_IDLE;
      fault_inv_d   = 1'b0;
      fault_stall_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.brake)         state_d = S_BRAKE;
          else if (hall_valid_d) state_d = S_RUN;
        end
        S_RUN: begin
          if (duty_nz && !hall_acc) stall_d = stall_q + 1'b1;
          if (!hall_valid_d) begin
            state_d     = S_FAULT;
            fault_inv_d = 1'b1;
          end else if (duty_nz && !hall_acc && stall_q == SW'(STALL_CYCLES - 1)) begin
            state_d       = S_FAULT;
            fault_stall_d = 1'b1;
          end else if (bus.brake) begin
            state_d = S_BRAKE;
          end else if (hall_acc || dir_tgl) begin
            state_d = S_BLANK;
            blank_d = '0;
          end
        end
        S_BLANK: begin
          stall_d = hall_acc ? '0 : stall_q;
          if (!hall_valid_d) begin
            state_d     = S_FAULT;
            fault_inv_d = 1'b1;
          end else if (hall_acc || dir_tgl) begin
            blank_d = '0;
          end else if (blank_q == BW'(COMM_BLANK_CYCLES - 1)) begin
            state_d = bus.brake ? S_BRAKE : S_RUN;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
        S_BRAKE: begin
          if (!hall_valid_d) begin
            state_d     = S_FAULT;
            fault_inv_d = 1'b1;
          end else if (!bus.brake) begin
            state_d = S_RUN;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
      // The first acceptance out of reset (IDLE) is not a commutation.
      if (hall_acc && hall_valid_d &&
          (state_q == S_RUN || state_q == S_BLANK || state_q == S_BRAKE)) begin
        count_d = dir_q ? count_q + 16'd1 : count_q - 16'd1;
      end
    end
  end

  // Phase roles for the next cycle; bit 0 = A, bit 1 = B, bit 2 = C.
  always_comb begin
    fwd_pwm = '0;
    fwd_low = '0;
    case (hall_flt_d)
      3'b101:  begin fwd_pwm = 3'b001; fwd_low = 3'b010; end
      3'b100:  begin fwd_pwm = 3'b001; fwd_low = 3'b100; end
      3'b110:  begin fwd_pwm = 3'b010; fwd_low = 3'b100; end
      3'b010:  begin fwd_pwm = 3'b010; fwd_low = 3'b001; end
      3'b011:  begin fwd_pwm = 3'b100; fwd_low = 3'b001; end
      3'b001:  begin fwd_pwm = 3'b100; fwd_low = 3'b010; end
      default: begin fwd_pwm = '0;     fwd_low = '0;     end
    endcase
    pwm_mask = '0;
    low_mask = '0;
    if (state_d == S_RUN) begin
      pwm_mask = bus.direction ? fwd_pwm : fwd_low;
      low_mask = bus.direction ? fwd_low : fwd_pwm;
    end else if (state_d == S_BRAKE) begin
      low_mask = 3'b111;
    end
    hz_d     = ~(pwm_mask | low_mask);
    duty_a_d = pwm_mask[0] ? bus.duty_cycle_in : '0;
    duty_b_d = pwm_mask[1] ? bus.duty_cycle_in : '0;
    duty_c_d = pwm_mask[2] ? bus.duty_cycle_in : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hall_s1_q     <= '0;
      hall_s2_q     <= '0;
      hall_flt_q    <= '0;
      hall_cand_q   <= '0;
      flt_cnt_q     <= '0;
      state_q       <= S_IDLE;
      blank_q       <= '0;
      stall_q       <= '0;
      dir_q         <= 1'b1;
      fault_inv_q   <= 1'b0;
      fault_stall_q <= 1'b0;
      count_q       <= '0;
      duty_a_q      <= '0;
      duty_b_q      <= '0;
      duty_c_q      <= '0;
      hz_q          <= '1;
    end else begin
      hall_s1_q     <= bus.hall;
      hall_s2_q     <= hall_s1_q;
      hall_flt_q    <= hall_flt_d;
      hall_cand_q   <= hall_cand_d;
      flt_cnt_q     <= flt_cnt_d;
      state_q       <= state_d;
      blank_q       <= blank_d;
      stall_q       <= stall_d;
      dir_q         <= bus.direction;
      fault_inv_q   <= fault_inv_d;
      fault_stall_q <= fault_stall_d;
      count_q       <= count_d;
      duty_a_q      <= duty_a_d;
      duty_b_q      <= duty_b_d;
      duty_c_q      <= duty_c_d;
      hz_q          <= hz_d;
    end
  end

  assign bus.duty_a             = duty_a_q;
  assign bus.duty_b             = duty_b_q;
  assign bus.duty_c             = duty_c_q;
  assign bus.high_z_a           = hz_q[0];
  assign bus.high_z_b           = hz_q[1];
  assign bus.high_z_c           = hz_q[2];
  assign bus.fault_invalid_hall = fault_inv_q;
  assign bus.fault_stall        = fault_stall_q;
  assign bus.comm_count         = count_q;

endmodule
